// File: rtl/psram_arbiter.sv
// Two-port arbiter/sequencer for async-mode 16-bit PSRAM (V read-only, H read/write), registered pins.
// Optional starvation guard for port H: define PSRAM_ARB_STARVE_GUARD_EN.
module psram_arbiter #(
   parameter int ADDR_W        = 23,
   parameter int ACCESS_CYCLES = 4,
   parameter int STARVE_LIMIT  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              v_req,
   input  logic [ADDR_W-1:0] v_addr,
   output logic              v_ack,
   output logic [15:0]       v_rdata,
   input  logic              h_req,
   input  logic              h_we,
   input  logic [ADDR_W-1:0] h_addr,
   input  logic [15:0]       h_wdata,
   input  logic [1:0]        h_be,
   output logic              h_ack,
   output logic [15:0]       h_rdata,
   output logic [ADDR_W-1:0] MemAdr,
   input  logic [15:0]       mem_dq_i,
   output logic [15:0]       mem_dq_o,
   output logic              mem_dq_oe,
   output logic              MemOE,
   output logic              MemWR,
   output logic              RamCS,
   output logic              RamLB,
   output logic              RamUB,
   output logic              busy
);

   if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_param_check
      $error("psram_arbiter: ACCESS_CYCLES and STARVE_LIMIT must be in 1..15");
   end

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

   state_t            state, state_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic              sel_h, sel_h_nxt;
   logic              op_we, op_we_nxt;
   logic [ADDR_W-1:0] adr_nxt;
   logic [15:0]       dq_o_nxt, v_rdata_nxt, h_rdata_nxt;
   logic              dq_oe_nxt, oe_nxt, wr_nxt, cs_nxt, lb_nxt, ub_nxt;
   logic              v_ack_nxt, h_ack_nxt, busy_nxt;
   logic              grant_v, grant_h, starve_force;

`ifdef PSRAM_ARB_STARVE_GUARD_EN
   logic [3:0] starve_cnt, starve_nxt;

   assign starve_force = (starve_cnt >= 4'(STARVE_LIMIT));

   // Counts V grants that bypass a waiting H; any H grant or idle H clears it.
   always_comb begin
      starve_nxt = starve_cnt;
      if (state == IDLE) begin
         if (!h_req || grant_h)
            starve_nxt = 4'd0;
         else if (grant_v && starve_cnt != 4'hF)
            starve_nxt = starve_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) starve_cnt <= 4'd0;
      else       starve_cnt <= starve_nxt;
   end
`else
   assign starve_force = 1'b0;
`endif

   assign grant_h = h_req && (!v_req || starve_force);
   assign grant_v = v_req && !grant_h;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      sel_h_nxt   = sel_h;
      op_we_nxt   = op_we;
      adr_nxt     = MemAdr;
      dq_o_nxt    = mem_dq_o;
      dq_oe_nxt   = mem_dq_oe;
      oe_nxt      = MemOE;
      wr_nxt      = MemWR;
      cs_nxt      = RamCS;
      lb_nxt      = RamLB;
      ub_nxt      = RamUB;
      v_ack_nxt   = 1'b0;
      h_ack_nxt   = 1'b0;
      v_rdata_nxt = v_rdata;
      h_rdata_nxt = h_rdata;
      busy_nxt    = busy;

      unique case (state)
         IDLE: begin
            busy_nxt = 1'b0;
            if (grant_v || grant_h) begin
               state_nxt = SETUP;
               busy_nxt  = 1'b1;
               sel_h_nxt = grant_h;
               op_we_nxt = grant_h && h_we;
               adr_nxt   = grant_h ? h_addr : v_addr;
               cs_nxt    = 1'b0;
               if (grant_h && h_we) begin
                  lb_nxt    = ~h_be[0];
                  ub_nxt    = ~h_be[1];
                  dq_o_nxt  = h_wdata;
                  dq_oe_nxt = 1'b1;
               end else begin
                  lb_nxt    = 1'b0;
                  ub_nxt    = 1'b0;
                  dq_oe_nxt = 1'b0;
               end
            end
         end
         SETUP: begin
            state_nxt = ACCESS;
            cnt_nxt   = 4'(ACCESS_CYCLES - 1);
            oe_nxt    = op_we;
            wr_nxt    = ~op_we;
         end
         ACCESS: begin
            if (cnt == 4'd0) begin
               // Read data is sampled while OE is still low, on the edge that releases the strobes.
               state_nxt = RECOVER;
               oe_nxt    = 1'b1;
               wr_nxt    = 1'b1;
               cs_nxt    = 1'b1;
               lb_nxt    = 1'b1;
               ub_nxt    = 1'b1;
               v_ack_nxt = ~sel_h;
               h_ack_nxt = sel_h;
               if (!op_we) begin
                  if (sel_h) h_rdata_nxt = mem_dq_i;
                  else       v_rdata_nxt = mem_dq_i;
               end
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         RECOVER: begin
            state_nxt = IDLE;
            dq_oe_nxt = 1'b0;
            busy_nxt  = 1'b0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         sel_h     <= 1'b0;
         op_we     <= 1'b0;
         MemAdr    <= '0;
         mem_dq_o  <= 16'h0000;
         mem_dq_oe <= 1'b0;
         MemOE     <= 1'b1;
         MemWR     <= 1'b1;
         RamCS     <= 1'b1;
         RamLB     <= 1'b1;
         RamUB     <= 1'b1;
         v_ack     <= 1'b0;
         h_ack     <= 1'b0;
         v_rdata   <= 16'h0000;
         h_rdata   <= 16'h0000;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         sel_h     <= sel_h_nxt;
         op_we     <= op_we_nxt;
         MemAdr    <= adr_nxt;
         mem_dq_o  <= dq_o_nxt;
         mem_dq_oe <= dq_oe_nxt;
         MemOE     <= oe_nxt;
         MemWR     <= wr_nxt;
         RamCS     <= cs_nxt;
         RamLB     <= lb_nxt;
         RamUB     <= ub_nxt;
         v_ack     <= v_ack_nxt;
         h_ack     <= h_ack_nxt;
         v_rdata   <= v_rdata_nxt;
         h_rdata   <= h_rdata_nxt;
         busy      <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter: table of H transactions against a byte-lane PSRAM model,
// plus sequences for V/H tie, mid-access reset and starvation.
module tb_psram_arbiter;

   localparam int AW = 23;

   logic          clk, reset;
   logic          v_req, v_ack, h_req, h_we, h_ack;
   logic [AW-1:0] v_addr, h_addr, MemAdr;
   logic [15:0]   v_rdata, h_rdata, h_wdata, mem_dq_i, mem_dq_o;
   logic [1:0]    h_be;
   logic          mem_dq_oe, MemOE, MemWR, RamCS, RamLB, RamUB, busy;

   int checks = 0;
   int failures = 0;

   psram_arbiter dut (
      .clk(clk), .reset(reset),
      .v_req(v_req), .v_addr(v_addr), .v_ack(v_ack), .v_rdata(v_rdata),
      .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_be(h_be),
      .h_ack(h_ack), .h_rdata(h_rdata),
      .MemAdr(MemAdr), .mem_dq_i(mem_dq_i), .mem_dq_o(mem_dq_o), .mem_dq_oe(mem_dq_oe),
      .MemOE(MemOE), .MemWR(MemWR), .RamCS(RamCS), .RamLB(RamLB), .RamUB(RamUB), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] mem [256];
   initial for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

   always @(posedge clk) begin
      if (!RamCS && !MemWR && mem_dq_oe) begin
         if (!RamLB) mem[MemAdr[7:0]][7:0]  <= mem_dq_o[7:0];
         if (!RamUB) mem[MemAdr[7:0]][15:8] <= mem_dq_o[15:8];
      end
   end
   assign mem_dq_i = (!RamCS && !MemOE) ? mem[MemAdr[7:0]] : 16'h0BAD;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [15:0]   wdata;
      logic [1:0]    be;
      logic [1:0]    exp_ublb;
      logic [15:0]   exp_rdata;
   } vec_t;

   vec_t vecs[8];

   task automatic run_h(input vec_t v);
      int lat = 0, acks = 0, wr_lo = 0, oe_lo = 0, cs_lo = 0, doe = 0;
      logic [1:0]  ublb = 2'b11;
      logic        dq_bad = 1'b0, bus_bad = 1'b0;
      logic [15:0] rd = 16'h0;
      h_we = v.we; h_addr = v.addr; h_wdata = v.wdata; h_be = v.be; h_req = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (!MemWR) wr_lo++;
         if (!MemOE) oe_lo++;
         if (!RamCS) cs_lo++;
         if (mem_dq_oe) begin
            doe++;
            if (mem_dq_o !== v.wdata) dq_bad = 1'b1;
         end
         if (!MemWR || !MemOE) ublb = {RamUB, RamLB};
         if ((!MemOE && !MemWR) || (mem_dq_oe && !MemOE) || v_ack) bus_bad = 1'b1;
         if (h_ack) begin
            acks++;
            if (lat == 0) begin
               lat = k;
               rd  = h_rdata;
            end
            h_req = 1'b0;
         end
      end
      check("h_latency", 32'(lat), 32'd6);
      check("h_ack_pulses", 32'(acks), 32'd1);
      check("memwr_low_cycles", 32'(wr_lo), v.we ? 32'd4 : 32'd0);
      check("memoe_low_cycles", 32'(oe_lo), v.we ? 32'd0 : 32'd4);
      check("ramcs_low_cycles", 32'(cs_lo), 32'd5);
      check("ub_lb", 32'(ublb), 32'(v.exp_ublb));
      check("dq_oe_cycles", 32'(doe), v.we ? 32'd6 : 32'd0);
      check("bus_rules", 32'(bus_bad), 32'd0);
      if (v.we) check("dq_o_data", 32'(dq_bad), 32'd0);
      else      check("h_rdata", 32'(rd), 32'(v.exp_rdata));
   endtask

   initial begin
      int t_v, t_h, nv, nh;
      logic both;

      vecs[0] = '{1'b1, 23'h10, 16'hA5C3, 2'b11, 2'b00, 16'h0000};
      vecs[1] = '{1'b0, 23'h10, 16'h0000, 2'b00, 2'b00, 16'hA5C3};
      vecs[2] = '{1'b1, 23'h10, 16'h1234, 2'b01, 2'b10, 16'h0000};
      vecs[3] = '{1'b0, 23'h10, 16'h0000, 2'b00, 2'b00, 16'hA534};
      vecs[4] = '{1'b1, 23'h20, 16'hBEEF, 2'b10, 2'b01, 16'h0000};
      vecs[5] = '{1'b0, 23'h20, 16'h0000, 2'b00, 2'b00, 16'hBE00};
      vecs[6] = '{1'b1, 23'h30, 16'hFFFF, 2'b00, 2'b11, 16'h0000};
      vecs[7] = '{1'b0, 23'h30, 16'h0000, 2'b00, 2'b00, 16'h0000};

      reset = 1'b1; v_req = 1'b0; v_addr = '0; h_req = 1'b0; h_we = 1'b0;
      h_addr = '0; h_wdata = 16'h0; h_be = 2'b00;
      repeat (3) @(negedge clk);
      check("reset_ctrl", 32'({MemOE, MemWR, RamCS, RamLB, RamUB, mem_dq_oe, v_ack, h_ack, busy}),
            32'b111110000);
      check("reset_addr", 32'(MemAdr), 32'h0);
      check("reset_dq_o", 32'(mem_dq_o), 32'h0);
      check("reset_rdata", 32'({v_rdata, h_rdata}), 32'h0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_h(vecs[i]);

      // Tie: V read of 0x10 and H read of 0x20 presented together.
      v_addr = 23'h10; v_req = 1'b1;
      h_addr = 23'h20; h_we = 1'b0; h_be = 2'b00; h_req = 1'b1;
      t_v = 0; t_h = 0; both = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (v_ack && h_ack) both = 1'b1;
         if (v_ack) begin
            if (t_v == 0) begin
               t_v = k;
               check("tie_v_rdata", 32'(v_rdata), 32'hA534);
            end
            v_req = 1'b0;
         end
         if (h_ack) begin
            if (t_h == 0) begin
               t_h = k;
               check("tie_h_rdata", 32'(h_rdata), 32'hBE00);
            end
            h_req = 1'b0;
         end
      end
      check("tie_v_latency", 32'(t_v), 32'd6);
      check("tie_h_after_v", 32'(t_h - t_v), 32'd7);
      check("tie_both_acks", 32'(both), 32'd0);
      check("tie_v_rdata_held", 32'(v_rdata), 32'hA534);

      // Reset during the second ACCESS cycle of an H write.
      h_we = 1'b1; h_addr = 23'h40; h_wdata = 16'h5555; h_be = 2'b11; h_req = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1; h_req = 1'b0;
      @(negedge clk);
      check("midreset_strobes", 32'({MemOE, MemWR, RamCS, RamLB, RamUB}), 32'b11111);
      check("midreset_dq_oe", 32'(mem_dq_oe), 32'd0);
      check("midreset_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      nh = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (h_ack || v_ack) nh++;
      end
      check("midreset_no_ack", 32'(nh), 32'd0);

      // Starvation: both ports held high.
      v_addr = 23'h10; v_req = 1'b1;
      h_we = 1'b0; h_addr = 23'h10; h_req = 1'b1;
      nv = 0; nh = 0;
`ifdef PSRAM_ARB_STARVE_GUARD_EN
      for (int k = 0; k < 150 && nh == 0; k++) begin
         @(negedge clk);
         if (h_ack) nh++;
         else if (v_ack) nv++;
      end
      check("starve_h_acked", 32'(nh), 32'd1);
      check("starve_v_before_h", 32'(nv), 32'd8);
      h_req = 1'b0; v_req = 1'b0;
`else
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (h_ack) nh++;
         if (v_ack) nv++;
      end
      check("starve_no_h_ack", 32'(nh), 32'd0);
      check("starve_v_progress", 32'(nv >= 13), 32'd1);
      v_req = 1'b0;
      for (int k = 0; k < 20 && nh == 0; k++) begin
         @(negedge clk);
         if (h_ack) nh++;
      end
      check("starve_h_after_v_drop", 32'(nh), 32'd1);
      h_req = 1'b0;
`endif
      repeat (10) @(negedge clk);
      check("final_idle", 32'({busy, RamCS}), 32'b01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/psram_arbiter.md
Name: psram_arbiter

Overview:
- Arbitrates the board's asynchronous-mode cellular RAM (16-bit PSRAM) between two requesters: the video line fetcher (port V, read-only) and the host/pattern writer (port H, read/write).
- Sequences each access as chip-select, strobe, wait and recover, and drives registered memory control pins.
- Sits between the requesters and the top-level MemDB tri-state buffer.
- RamAdv, RamClk and RamCRE are tied off in the top level for asynchronous mode and are not driven here.

Parameters:
- ADDR_W, 23: word-address width; drives MemAdr[ADDR_W:1].
- ACCESS_CYCLES, 4: clocks that OE/WE stay low. At 50 MHz this is ≥70 ns. Legal range 1..15.
- STARVE_LIMIT, 8: consecutive V grants allowed while H is pending. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- v_req  in  1  video read request; held until v_ack
- v_addr  in  ADDR_W  video word address
- v_ack  out  1  one-cycle pulse; v_rdata valid in the same cycle
- v_rdata  out  16  video read data
- h_req  in  1  host request; held until h_ack
- h_we  in  1  1 = write, 0 = read
- h_addr  in  ADDR_W  host word address
- h_wdata  in  16  host write data
- h_be  in  2  byte enables; [1] upper, [0] lower
- h_ack  out  1  one-cycle pulse; h_rdata valid in the same cycle
- h_rdata  out  16  host read data
- MemAdr  out  ADDR_W  memory address
- mem_dq_i  in  16  MemDB input side
- mem_dq_o  out  16  MemDB output side
- mem_dq_oe  out  1  MemDB drive enable
- MemOE  out  1  output enable, active low
- MemWR  out  1  write enable, active low
- RamCS  out  1  chip select, active low
- RamLB  out  1  lower byte enable, active low
- RamUB  out  1  upper byte enable, active low
- busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered.
- Reset values:
  - MemOE = MemWR = RamCS = RamLB = RamUB = 1.
  - MemAdr = 0, mem_dq_o = 0, mem_dq_oe = 0.
  - v_ack = h_ack = 0, v_rdata = h_rdata = 0, busy = 0.
  - State is IDLE. Any access in flight is abandoned and its ack is never issued.
- States: IDLE, SETUP, ACCESS, RECOVER.
- IDLE:
  - Samples the requests. v_req has priority over h_req; on a tie, V wins.
  - Latches the winning port, address and operation, plus write data/BE for H.
  - Moves to SETUP. With no request it stays in IDLE.
- SETUP (1 cycle):
  - MemAdr is valid, RamCS = 0.
  - LB/UB: H write uses ~h_be; any read uses 00.
  - Write: mem_dq_o = wdata and mem_dq_oe = 1.
- ACCESS (ACCESS_CYCLES cycles, timed by a 4-bit down-counter):
  - Read: MemOE = 0. mem_dq_i is captured on the clock edge that ends the final ACCESS cycle.
  - Write: MemWR = 0, data is still driven.
- RECOVER (1 cycle):
  - RamCS, MemOE, MemWR, LB and UB return high.
  - For writes, mem_dq_oe stays 1 for hold time and drops when IDLE is entered.
  - The granted port's ack = 1 for this cycle. Read data is presented on that port's rdata and held until that port's next ack.
  - Moves to IDLE.
- Timing:
  - Grant in cycle t gives ack in cycle t+2+ACCESS_CYCLES.
  - Back-to-back period is ACCESS_CYCLES+3 cycles.
- Protocol violations:
  - req is sampled only in IDLE.
  - If a requester drops req after its grant, the access still completes and ack still pulses.
  - Address or data changes after the grant are ignored.
- Bus rules:
  - MemOE and MemWR are never low in the same cycle.
  - mem_dq_oe is never 1 while MemOE = 0.
  - h_be = 00 on a write performs the cycle with LB = UB = 1: no bytes are written, but the write is still acked.

Optional Feature:
- Macro: PSRAM_ARB_STARVE_GUARD_EN.
- Defined:
  - A 4-bit counter counts consecutive V grants while h_req is high.
  - When the count reaches STARVE_LIMIT, the next IDLE grant goes to H even if v_req is high.
  - The counter clears on any H grant, when h_req is low in IDLE, and on reset.
- Undefined: strict fixed priority; H can starve indefinitely.

Test Plan:
- Reset, then H write addr 0x000010, data 0xA5C3, be 11: ack at grant+6 (ACCESS_CYCLES=4); MemWR low exactly 4 cycles; RamCS low 5 cycles; mem_dq_o = 0xA5C3 while oe; LB = UB = 0.
- H read 0x000010 with memory model returning 0xA5C3: h_ack pulses once; h_rdata = 0xA5C3; MemOE low 4 cycles; mem_dq_oe stays 0 throughout.
- v_req and h_req asserted in the same cycle: v_ack first, h_ack exactly 7 cycles later; never both acks in one cycle.
- H write be = 01, data 0x1234: RamLB = 0, RamUB = 1 during the access; a following read of the model shows only the low byte changed to 0x34.
- Assert reset during cycle 2 of ACCESS: the next cycle has all strobes high, mem_dq_oe = 0, busy = 0, and no ack ever issues for that access.
- With the macro defined, v_req held high and h_req high: h_ack after exactly 8 v_acks. Without the macro: no h_ack while v_req stays high.
